// File: rtl/div_hilo_seq_if.sv
// Signal bundle between the control unit, the HI/LO divide sequencer and the
// combinational divider; the sequencer takes the slave view.
interface div_hilo_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_a;
    logic [31:0] div_m;
    logic [63:0] div_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport slave (
        input  start, is_signed, dividend, divisor, div_q,
        output div_a, div_m, hi, lo, busy, done, div_zero
    );

    modport master (
        output start, is_signed, dividend, divisor, div_q,
        input  div_a, div_m, hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_hilo_seq.sv
// Multi-cycle wrapper around a combinational restoring divider: feeds operand
// magnitudes, waits SETTLE_CYCLES, then sign-corrects into HI (rem) / LO (quot).
module div_hilo_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    div_hilo_seq_if.slave    bus
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sa_q, sa_d;
    logic          sm_q, sm_d;
    logic [31:0]   div_a_q, div_a_d;
    logic [31:0]   div_m_q, div_m_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;

    logic          sa_in, sm_in;
    logic [31:0]   quot_raw, rem_raw;

    assign sa_in    = bus.is_signed & bus.dividend[31];
    assign sm_in    = bus.is_signed & bus.divisor[31];
    assign rem_raw  = bus.div_q[63:32];
    assign quot_raw = bus.div_q[31:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sa_d       = sa_q;
        sm_d       = sm_q;
        div_a_d    = div_a_q;
        div_m_d    = div_m_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == 32'd0) begin
                        // Divide-by-zero bypasses the divider entirely.
                        hi_d       = bus.dividend;
                        lo_d       = 32'hFFFF_FFFF;
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        sa_d       = sa_in;
                        sm_d       = sm_in;
                        div_a_d    = sa_in ? -bus.dividend : bus.dividend;
                        div_m_d    = sm_in ? -bus.divisor  : bus.divisor;
                        cnt_d      = CW'(SETTLE_CYCLES - 1);
                        div_zero_d = 1'b0;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    lo_d    = (sa_q ^ sm_q) ? -quot_raw : quot_raw;
                    hi_d    = sa_q ? -rem_raw : rem_raw;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sa_q       <= 1'b0;
            sm_q       <= 1'b0;
            div_a_q    <= '0;
            div_m_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sa_q       <= sa_d;
            sm_q       <= sm_d;
            div_a_q    <= div_a_d;
            div_m_q    <= div_m_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.div_a    = div_a_q;
    assign bus.div_m    = div_m_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_hilo_seq.sv
// Directed bench for div_hilo_seq with a behavioural unsigned divider on
// div_a/div_m/div_q and SETTLE_CYCLES = 4.
module tb_div_hilo_seq;
    logic clk;
    logic clr;
    int   vectors;
    int   miscompares;

    div_hilo_seq_if bus ();

    div_hilo_seq #(.SETTLE_CYCLES(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational restoring divider stand-in: {remainder, quotient}.
    always_comb begin
        if (bus.div_m == 32'd0)
            bus.div_q = {bus.div_a, 32'hFFFF_FFFF};
        else
            bus.div_q = {bus.div_a % bus.div_m, bus.div_a / bus.div_m};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one divide and check latency, busy window, results and retention.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] m, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int lat;
        int busy_cycles;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.busy) busy_cycles++;
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".lo"}, bus.lo, exp_lo);
        check({tag, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
        @(posedge clk);
        #1;
        check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(exp_lat + 1));
        check({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".done_after"}, {31'd0, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".hi_hold"}, bus.hi, exp_hi);
        check({tag, ".lo_hold"}, bus.lo, exp_lo);
        $display("op %s A=%h M=%h signed=%0b -> hi=%h lo=%h dz=%0b lat=%0d",
                 tag, a, m, sgn, bus.hi, bus.lo, bus.div_zero, lat);
    endtask

    initial begin
        int done_cnt;
        vectors     = 0;
        miscompares = 0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.done", {31'd0, bus.done}, 32'd0);
        check("rst.dz", {31'd0, bus.div_zero}, 32'd0);
        check("rst.hi", bus.hi, 32'd0);
        check("rst.lo", bus.lo, 32'd0);
        check("rst.div_a", bus.div_a, 32'd0);
        check("rst.div_m", bus.div_m, 32'd0);
        $display("reset applied");
        clr = 1'b0;

        run_op("udiv", 1'b0, 32'd100, 32'd7, 4, 32'd2, 32'd14, 1'b0);
        run_op("udiv_big", 1'b0, 32'hFFFF_FFF9, 32'd2, 4, 32'd1, 32'h7FFF_FFFC, 1'b0);
        run_op("sdiv_negA", 1'b1, 32'hFFFF_FFF9, 32'd2, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("sdiv_both", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 4, 32'hFFFF_FFFE, 32'd14, 1'b0);
        run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4, 32'd0, 32'h8000_0000, 1'b0);
        run_op("div0", 1'b0, 32'h0000_1234, 32'd0, 0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("after_div0", 1'b0, 32'd100, 32'd7, 4, 32'd2, 32'd14, 1'b0);

        // Second start while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (bus.done) done_cnt++;
        check("sib.div_a", bus.div_a, 32'd100);
        check("sib.div_m", bus.div_m, 32'd7);
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                check("sib.hi", bus.hi, 32'd2);
                check("sib.lo", bus.lo, 32'd14);
            end
        end
        check("sib.done_pulses", 32'(done_cnt), 32'd1);
        $display("op start_while_busy done_pulses=%0d hi=%h lo=%h", done_cnt, bus.hi, bus.lo);

        // clr asserted on E2 aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'hFFFF_FFF9; bus.divisor = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr.busy", {31'd0, bus.busy}, 32'd0);
        check("clr.done", {31'd0, bus.done}, 32'd0);
        check("clr.hi", bus.hi, 32'd0);
        check("clr.lo", bus.lo, 32'd0);
        check("clr.div_a", bus.div_a, 32'd0);
        done_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("clr.no_done", 32'(done_cnt), 32'd0);
        $display("op clr_mid_op done_pulses=%0d hi=%h lo=%h", done_cnt, bus.hi, bus.lo);
        run_op("after_clr", 1'b0, 32'd100, 32'd7, 4, 32'd2, 32'd14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
